// File: rtl/rtc_cmd_ctrl.sv
// Command sequencer/arbiter in front of the RTC core: round-robin grant of two requesters,
// single-cycle update strobes, sticky event interrupt. Optional day counter: RTC_CTRL_DAY_CNT_EN.
module rtc_cmd_ctrl (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  cmd0_i,
    input  logic [1:0]  cmd1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic [1:0]  done_o,
    output logic [31:0] rdata_o,
    output logic        rtc_clock_update_o,
    output logic        rtc_alarm_update_o,
    output logic        rtc_timer_update_o,
    output logic [21:0] rtc_clock_o,
    output logic [9:0]  rtc_init_sec_cnt_o,
    output logic [21:0] rtc_alarm_o,
    output logic        rtc_alarm_en_o,
    output logic [16:0] rtc_timer_target_o,
    output logic        rtc_timer_en_o,
    output logic        rtc_timer_retrig_o,
    input  logic [21:0] rtc_clock_i,
    input  logic        rtc_event_i,
    input  logic        rtc_update_day_i,
    input  logic        irq_clr_i,
    output logic        irq_o
);

    localparam int unsigned CMD_W  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DAY_W  = 10;

    localparam logic [CMD_W-1:0] CMD_SET_CLOCK = 2'd0;
    localparam logic [CMD_W-1:0] CMD_SET_ALARM = 2'd1;
    localparam logic [CMD_W-1:0] CMD_SET_TIMER = 2'd2;
    localparam logic [CMD_W-1:0] CMD_READ      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_q;
    logic               grant_q;
    logic               last_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [DAY_W-1:0]   day_c;

    logic               win_c;
    logic [CMD_W-1:0]   win_cmd_c;
    logic [DATA_W-1:0]  win_wdata_c;

    // Round-robin pick: on contention favour the port not granted last
    always_comb begin
        win_c = 1'b0;
        if (req_i[0] && req_i[1]) begin
            win_c = ~last_q;
        end else begin
            win_c = req_i[1];
        end
        win_cmd_c   = win_c ? cmd1_i   : cmd0_i;
        win_wdata_c = win_c ? wdata1_i : wdata0_i;
    end

    // Strobes and config buses are loaded on the grant edge so they are visible in APPLY
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q            <= ST_IDLE;
            grant_q            <= 1'b0;
            last_q             <= 1'b1;
            cmd_q              <= CMD_READ;
            done_o             <= '0;
            rdata_o            <= '0;
            rtc_clock_update_o <= 1'b0;
            rtc_alarm_update_o <= 1'b0;
            rtc_timer_update_o <= 1'b0;
            rtc_clock_o        <= '0;
            rtc_init_sec_cnt_o <= '0;
            rtc_alarm_o        <= '0;
            rtc_alarm_en_o     <= 1'b0;
            rtc_timer_target_o <= '0;
            rtc_timer_en_o     <= 1'b0;
            rtc_timer_retrig_o <= 1'b0;
        end else begin
            rtc_clock_update_o <= 1'b0;
            rtc_alarm_update_o <= 1'b0;
            rtc_timer_update_o <= 1'b0;
            done_o             <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_q <= win_c;
                        cmd_q   <= win_cmd_c;
                        state_q <= ST_APPLY;
                        case (win_cmd_c)
                            CMD_SET_CLOCK: begin
                                rtc_clock_update_o <= 1'b1;
                                rtc_clock_o        <= win_wdata_c[21:0];
                                rtc_init_sec_cnt_o <= win_wdata_c[31:22];
                            end
                            CMD_SET_ALARM: begin
                                rtc_alarm_update_o <= 1'b1;
                                rtc_alarm_o        <= win_wdata_c[21:0];
                                rtc_alarm_en_o     <= win_wdata_c[31];
                            end
                            CMD_SET_TIMER: begin
                                rtc_timer_update_o <= 1'b1;
                                rtc_timer_target_o <= win_wdata_c[16:0];
                                rtc_timer_retrig_o <= win_wdata_c[30];
                                rtc_timer_en_o     <= win_wdata_c[31];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_APPLY: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    rdata_o <= {day_c, rtc_clock_i};
                    done_o  <= grant_q ? 2'b10 : 2'b01;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    last_q  <= grant_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky interrupt; a new event outranks a simultaneous clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_o <= 1'b0;
        end else if (rtc_event_i) begin
            irq_o <= 1'b1;
        end else if (irq_clr_i) begin
            irq_o <= 1'b0;
        end
    end

`ifdef RTC_CTRL_DAY_CNT_EN
    logic [DAY_W-1:0] day_q;

    // Day counter restarts with every applied SET_CLOCK, which outranks a day pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            day_q <= '0;
        end else if (state_q == ST_APPLY && cmd_q == CMD_SET_CLOCK) begin
            day_q <= '0;
        end else if (rtc_update_day_i) begin
            day_q <= day_q + DAY_W'(1);
        end
    end

    assign day_c = day_q;
`else
    logic unused_day_c;

    assign day_c        = '0;
    assign unused_day_c = ^{rtc_update_day_i, cmd_q};
`endif

endmodule

// File: tb/tb_rtc_cmd_ctrl.sv
// Directed bench for rtc_cmd_ctrl with a response scoreboard; build with +define+RTC_CTRL_DAY_CNT_EN
// to cover the day counter.
module tb_rtc_cmd_ctrl;

    localparam logic [1:0] C_CLK = 2'd0;
    localparam logic [1:0] C_ALM = 2'd1;
    localparam logic [1:0] C_TMR = 2'd2;
    localparam logic [1:0] C_RD  = 2'd3;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  req_i;
    logic [1:0]  cmd0_i, cmd1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        rtc_clock_update_o, rtc_alarm_update_o, rtc_timer_update_o;
    logic [21:0] rtc_clock_o;
    logic [9:0]  rtc_init_sec_cnt_o;
    logic [21:0] rtc_alarm_o;
    logic        rtc_alarm_en_o;
    logic [16:0] rtc_timer_target_o;
    logic        rtc_timer_en_o, rtc_timer_retrig_o;
    logic [21:0] rtc_clock_i;
    logic        rtc_event_i, rtc_update_day_i, irq_clr_i;
    logic        irq_o;

    rtc_cmd_ctrl dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i),
        .cmd0_i(cmd0_i), .cmd1_i(cmd1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .done_o(done_o), .rdata_o(rdata_o),
        .rtc_clock_update_o(rtc_clock_update_o), .rtc_alarm_update_o(rtc_alarm_update_o),
        .rtc_timer_update_o(rtc_timer_update_o),
        .rtc_clock_o(rtc_clock_o), .rtc_init_sec_cnt_o(rtc_init_sec_cnt_o),
        .rtc_alarm_o(rtc_alarm_o), .rtc_alarm_en_o(rtc_alarm_en_o),
        .rtc_timer_target_o(rtc_timer_target_o), .rtc_timer_en_o(rtc_timer_en_o),
        .rtc_timer_retrig_o(rtc_timer_retrig_o),
        .rtc_clock_i(rtc_clock_i), .rtc_event_i(rtc_event_i),
        .rtc_update_day_i(rtc_update_day_i), .irq_clr_i(irq_clr_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the config buses and day counter
    logic [21:0] m_clock;
    logic [9:0]  m_sub;
    logic [21:0] m_alarm;
    logic        m_alarm_en;
    logic [16:0] m_tgt;
    logic        m_ten, m_retrig;
    logic [9:0]  m_day;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clock = '0; m_sub = '0; m_alarm = '0; m_alarm_en = 1'b0;
        m_tgt = '0; m_ten = 1'b0; m_retrig = 1'b0; m_day = '0;
    endtask

    function automatic logic [31:0] exp_rdata();
`ifdef RTC_CTRL_DAY_CNT_EN
        return {m_day, rtc_clock_i};
`else
        return {10'h0, rtc_clock_i};
`endif
    endfunction

    task automatic model_apply(input logic [1:0] cmd, input logic [31:0] wd);
        case (cmd)
            C_CLK: begin m_clock = wd[21:0]; m_sub = wd[31:22]; m_day = '0; end
            C_ALM: begin m_alarm = wd[21:0]; m_alarm_en = wd[31]; end
            C_TMR: begin m_tgt = wd[16:0]; m_retrig = wd[30]; m_ten = wd[31]; end
            default: ;
        endcase
    endtask

    task automatic check_buses(input string tag);
        chk({tag, "_clock"},  32'(rtc_clock_o),        32'(m_clock));
        chk({tag, "_sub"},    32'(rtc_init_sec_cnt_o), 32'(m_sub));
        chk({tag, "_alarm"},  32'({rtc_alarm_en_o, rtc_alarm_o}), 32'({m_alarm_en, m_alarm}));
        chk({tag, "_timer"},  32'({rtc_timer_en_o, rtc_timer_retrig_o, rtc_timer_target_o}),
                              32'({m_ten, m_retrig, m_tgt}));
    endtask

    function automatic logic [2:0] strb();
        return {rtc_timer_update_o, rtc_alarm_update_o, rtc_clock_update_o};
    endfunction

    function automatic logic [2:0] exp_strb(input logic [1:0] cmd);
        case (cmd)
            C_CLK:   return 3'b001;
            C_ALM:   return 3'b010;
            C_TMR:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic set_port(input int p, input logic [1:0] cmd, input logic [31:0] wd);
        if (p == 0) begin cmd0_i = cmd; wdata0_i = wd; end
        else        begin cmd1_i = cmd; wdata1_i = wd; end
        req_i[p] = 1'b1;
        model_apply(cmd, wd);
        sb_q.push_back('{done: (p == 0) ? 2'b01 : 2'b10, rdata: exp_rdata()});
    endtask

    // Waits (bounded) for the next done pulse, checks its distance in cycles and the scoreboard head
    task automatic wait_done(input string tag, input int exp_lat);
        exp_t e;
        int   k;
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (done_o == 2'b00 && k < 16);
        chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'(1));
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_done"},  32'(done_o), 32'(e.done));
            chk({tag, "_rdata"}, rdata_o, e.rdata);
        end
    endtask

    task automatic cmd_single(input string tag, input int p, input logic [1:0] cmd, input logic [31:0] wd);
        @(negedge clk_i);
        set_port(p, cmd, wd);
        @(negedge clk_i);
        chk({tag, "_strobe"}, 32'(strb()), 32'(exp_strb(cmd)));
        check_buses(tag);
        @(negedge clk_i);
        chk({tag, "_strobe_off"}, 32'({strb(), done_o}), 32'(0));
        wait_done(tag, 1);
        req_i[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; req_i = '0; cmd0_i = '0; cmd1_i = '0; wdata0_i = '0; wdata1_i = '0;
        rtc_clock_i = 22'h12_34_56; rtc_event_i = 1'b0; rtc_update_day_i = 1'b0; irq_clr_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_outs", 32'({done_o, strb(), irq_o}), 32'(0));
        chk("rst_rdata", rdata_o, 32'(0));
        check_buses("rst");
        rstn_i = 1'b1;

        // Both ports at once from reset: port 0 first, then port 1, then alternate
        @(negedge clk_i);
        set_port(0, C_ALM, 32'h8011_2233);
        set_port(1, C_RD,  32'hFFFF_FFFF);
        @(negedge clk_i);
        chk("arb_strobe", 32'(strb()), 32'(3'b010));
        check_buses("arb");
        wait_done("arb_p0", 2);
        set_port(0, C_RD, 32'h0);
        wait_done("arb_p1", 4);
        set_port(1, C_RD, 32'h0);
        wait_done("arb_p0b", 4);
        req_i[0] = 1'b0;
        wait_done("arb_p1b", 4);
        req_i[1] = 1'b0;

        // SET_CLOCK with sub-second preload
        cmd_single("setclk", 0, C_CLK, {10'h3, 22'h235958});
        chk("setclk_val", 32'({rtc_init_sec_cnt_o, rtc_clock_o}), {10'h3, 22'h235958});

        // SET_TIMER, then SET_ALARM must leave timer outputs alone
        rtc_clock_i = 22'h01_02_03;
        cmd_single("settmr", 1, C_TMR, {1'b1, 1'b1, 13'h1ABC, 17'h10});
        chk("settmr_val", 32'({rtc_timer_en_o, rtc_timer_retrig_o, rtc_timer_target_o}),
            32'({1'b1, 1'b1, 17'h10}));
        cmd_single("setalm", 0, C_ALM, 32'h0005_0000);
        chk("setalm_tmr", 32'({rtc_timer_en_o, rtc_timer_retrig_o, rtc_timer_target_o}),
            32'({1'b1, 1'b1, 17'h10}));

        // Interrupt: set and clear together -> set; clear alone -> cleared
        @(negedge clk_i);
        rtc_event_i = 1'b1; irq_clr_i = 1'b1;
        @(negedge clk_i);
        rtc_event_i = 1'b0;
        chk("irq_set_wins", 32'(irq_o), 32'(1));
        @(negedge clk_i);
        irq_clr_i = 1'b0;
        chk("irq_clr", 32'(irq_o), 32'(0));

        // 1025 day pulses then READ; then SET_CLOCK clears the count
        for (int i = 0; i < 1025; i++) begin
            @(negedge clk_i);
            rtc_update_day_i = 1'b1;
            m_day = m_day + 10'd1;
        end
        @(negedge clk_i);
        rtc_update_day_i = 1'b0;
        cmd_single("day_rd", 1, C_RD, 32'h0);
`ifdef RTC_CTRL_DAY_CNT_EN
        chk("day_val", 32'(rdata_o[31:22]), 32'(1));
`else
        chk("day_val", 32'(rdata_o[31:22]), 32'(0));
`endif
        cmd_single("day_clk", 0, C_CLK, 32'h0012_0000);
        cmd_single("day_rd2", 0, C_RD, 32'h0);
        chk("day_clr", 32'(rdata_o[31:22]), 32'(0));

        // Reset during SETTLE aborts the command and clears everything
        @(negedge clk_i);
        rtc_event_i = 1'b1;
        @(negedge clk_i);
        rtc_event_i = 1'b0;
        cmd0_i = C_TMR; wdata0_i = 32'h8000_0077; req_i[0] = 1'b1;
        @(negedge clk_i);
        chk("abort_strobe", 32'(strb()), 32'(3'b100));
        @(negedge clk_i);
        rstn_i = 1'b0;
        model_reset();
        #1;
        chk("abort_outs", 32'({done_o, strb(), irq_o}), 32'(0));
        chk("abort_rdata", rdata_o, 32'(0));
        check_buses("abort");
        @(negedge clk_i);
        req_i = '0;
        chk("abort_done", 32'(done_o), 32'(0));
        @(negedge clk_i);
        rstn_i = 1'b1;
        cmd_single("post_rst", 1, C_ALM, 32'h8023_5900);

        repeat (2) @(negedge clk_i);
        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
